icache_loader: RTL and testbench

Programming-side counterpart of the tile instruction-cache write port. It accepts a host word stream (valid/ready) carrying a start address, a length and instruction words. It replays those words as single-cycle `icache_write`/`icache_addr`/`icache_data` writes into one tile, and holds that tile in reset until the image is fully written. One loader sits beside each tile, or one is muxed across the mesh by the top level.

---
 rtl/icache_loader.sv | 180 ++++++++++++++++++
 tb/tb_icache_loader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_loader.sv
`default_nettype none
// ============================================================================
// Module   : icache_loader
// Brief    : Converts a host word stream (address, length, instruction words)
//            into single-cycle icache writes for one tile. The tile is held
//            in reset until a complete image has been written.
// Options  : ICACHE_LOADER_CHECKSUM_EN - adds a trailing XOR checksum word
//            and a sticky err flag that keeps the tile in reset on mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module icache_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    input  logic [INSTR_W-1:0] s_data,
    output logic               s_ready,
    output logic               icache_write,
    output logic [ADDR_W-1:0]  icache_addr,
    output logic [INSTR_W-1:0] icache_data,
    output logic               tile_nrst,
    output logic               busy,
    output logic               load_done,
    output logic               err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
`ifdef ICACHE_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4
    } state_t;

    // A full address space of writes; longer length words saturate to this.
    localparam logic [ADDR_W:0] c_max_len = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_one     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_zero    = '0;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr_ptr;
    logic [ADDR_W:0]     r_remaining;
    logic                r_write;
    logic [ADDR_W-1:0]   r_iaddr;
    logic [INSTR_W-1:0]  r_idata;
    logic                r_tile_nrst;
    logic                w_beat;
    logic [ADDR_W:0]     w_len;

    // Ready is withheld during reset so no beat is ever seen while rst is high.
    assign s_ready      = !rst && (r_state != S_DONE);
    assign w_beat       = s_valid && s_ready;
    assign w_len        = s_data[ADDR_W] ? c_max_len : {1'b0, s_data[ADDR_W-1:0]};
    assign busy         = (r_state != S_IDLE);
    assign load_done    = (r_state == S_DONE);
    assign icache_write = r_write;
    assign icache_addr  = r_iaddr;
    assign icache_data  = r_idata;
    assign tile_nrst    = r_tile_nrst;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; every stream-consuming state advances only on a beat.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) w_next = S_LEN;
            end
            S_LEN: begin
                if (w_beat) begin
                    if (w_len != c_zero) begin
                        w_next = S_DATA;
                    end else begin
`ifdef ICACHE_LOADER_CHECKSUM_EN
                        w_next = S_CHK;
`else
                        w_next = S_DONE;
`endif
                    end
                end
            end
            S_DATA: begin
                if (w_beat && (r_remaining == c_one)) begin
`ifdef ICACHE_LOADER_CHECKSUM_EN
                    w_next = S_CHK;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef ICACHE_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_beat) w_next = S_DONE;
            end
`endif
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Address/length tracking, registered write port and tile reset control.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_ptr  <= '0;
            r_remaining <= '0;
            r_write     <= 1'b0;
            r_iaddr     <= '0;
            r_idata     <= '0;
            r_tile_nrst <= 1'b0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_beat) begin
                        r_addr_ptr  <= s_data[ADDR_W-1:0];
                        r_tile_nrst <= 1'b0;
                    end
                end
                S_LEN: begin
                    if (w_beat) r_remaining <= w_len;
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_write     <= 1'b1;
                        r_iaddr     <= r_addr_ptr;
                        r_idata     <= s_data;
                        r_addr_ptr  <= r_addr_ptr + 1'b1;
                        r_remaining <= r_remaining - c_one;
                    end
                end
                // The last write is already on the port in DONE, so releasing
                // the tile on the DONE->IDLE edge never overtakes a write.
                S_DONE: r_tile_nrst <= !err;
                default: ;
            endcase
        end
    end

`ifdef ICACHE_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] r_acc;
    logic               r_err;

    assign err = r_err;

    // XOR accumulator over data words and sticky mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_err <= 1'b0;
        end else if (w_beat) begin
            case (r_state)
                S_IDLE: begin
                    r_acc <= '0;
                    r_err <= 1'b0;
                end
                S_DATA:  r_acc <= r_acc ^ s_data;
                S_CHK:   if (s_data != r_acc) r_err <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_loader
// Brief    : Directed bench for icache_loader. Expected writes are queued by
//            the stimulus and consumed by a separate write monitor.
// Options  : ICACHE_LOADER_CHECKSUM_EN - also appends checksum words and
//            exercises the err path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready, icache_write, tile_nrst, busy, load_done, err;
    logic [7:0]  icache_addr;
    logic [15:0] icache_data;

    icache_loader #(.ADDR_W(8), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .icache_write(icache_write),
        .icache_addr(icache_addr), .icache_data(icache_data),
        .tile_nrst(tile_nrst), .busy(busy), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    wr_t         sb_q[$];
    int          wr_cyc[$];
    logic [15:0] dbuf[256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst && load_done) done_cnt++;
        if (!rst && icache_write) begin
            wr_cnt++;
            wr_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         icache_addr, icache_data);
            end else begin
                e = sb_q.pop_front();
                chk("write_addr", {24'h0, icache_addr}, {24'h0, e.a});
                chk("write_data", {16'h0, icache_data}, {16'h0, e.d});
            end
        end
    end

    // Offer one word and return #1 after the edge on which it was accepted.
    task automatic send(input logic [15:0] w);
        logic rdy;
        int   n;
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        do begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance", w);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full load from dbuf; gap inserts stall cycles between beats.
    task automatic load(input logic [7:0] a, input logic [15:0] len, input int gap, input bit bad);
        int          n;
        logic [15:0] x;
        logic [7:0]  p;
        wr_t         e;
        n = len[8] ? 256 : int'(len[7:0]);
        x = '0;
        p = a;
        send({8'h00, a});
        if (gap > 0) idle(gap);
        send(len);
        if (gap > 0 && n > 0) idle(gap);
        for (int i = 0; i < n; i++) begin
            e.a = p;
            e.d = dbuf[i];
            sb_q.push_back(e);
            send(dbuf[i]);
            chk("write_latency", {31'h0, icache_write}, 32'h1);
            chk("write_addr_now", {24'h0, icache_addr}, {24'h0, p});
            x = x ^ dbuf[i];
            p = p + 8'h01;
            if (gap > 0 && i != n - 1) idle(gap);
        end
`ifdef ICACHE_LOADER_CHECKSUM_EN
        if (gap > 0) idle(gap);
        send(bad ? 16'h0000 : x);
`else
        if (bad) chk("bad_checksum_needs_macro", 32'h0, 32'h0);
`endif
    endtask

    // Called in the cycle after the final beat: DONE for one cycle, then IDLE.
    task automatic finish_load(input bit exp_nrst);
        s_valid = 1'b0;
        chk("done_pulse", {31'h0, load_done}, 32'h1);
        chk("ready_in_done", {31'h0, s_ready}, 32'h0);
        chk("nrst_in_done", {31'h0, tile_nrst}, 32'h0);
        idle(1);
        chk("done_one_cycle", {31'h0, load_done}, 32'h0);
        chk("busy_idle", {31'h0, busy}, 32'h0);
        chk("nrst_after", {31'h0, tile_nrst}, {31'h0, exp_nrst});
    endtask

    task automatic chk_reset();
        chk("rst_ready", {31'h0, s_ready}, 32'h0);
        chk("rst_write", {31'h0, icache_write}, 32'h0);
        chk("rst_addr", {24'h0, icache_addr}, 32'h0);
        chk("rst_data", {16'h0, icache_data}, 32'h0);
        chk("rst_nrst", {31'h0, tile_nrst}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, load_done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1ms, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int d0;
        int w0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {31'h0, s_ready}, 32'h1);
        idle(1);

        // Basic load: 0x10 / 3 words, back-to-back
        dbuf[0] = 16'hA001; dbuf[1] = 16'hA002; dbuf[2] = 16'hA003;
        wr_cyc.delete();
        d0 = done_cnt;
        load(8'h10, 16'h0003, 0, 1'b0);
        finish_load(1'b1);
        idle(2);
        chk("basic_done_count", done_cnt - d0, 32'd1);
        chk("basic_consecutive", wr_cyc[2] - wr_cyc[0], 32'd2);

        // Wrap and stall: 0xFE, length 4, s_valid every other cycle
        dbuf[0] = 16'h1111; dbuf[1] = 16'h2222; dbuf[2] = 16'h3333; dbuf[3] = 16'h4444;
        wr_cyc.delete();
        w0 = wr_cnt;
        load(8'hFE, 16'h0004, 1, 1'b0);
        finish_load(1'b1);
        chk("wrap_write_count", wr_cnt - w0, 32'd4);
        chk("stall_spacing", wr_cyc[1] - wr_cyc[0], 32'd2);

        // Length 0: no writes, still completes
        w0 = wr_cnt;
        d0 = done_cnt;
        load(8'h20, 16'h0000, 0, 1'b0);
        finish_load(1'b1);
        chk("len0_no_writes", wr_cnt - w0, 32'd0);
        chk("len0_done_count", done_cnt - d0, 32'd1);

        // Length 0x1FF saturates to 256
        for (int i = 0; i < 256; i++) dbuf[i] = 16'(i * 257) ^ 16'h5AC3;
        w0 = wr_cnt;
        load(8'h00, 16'h01FF, 0, 1'b0);
        finish_load(1'b1);
        idle(3);
        chk("sat_write_count", wr_cnt - w0, 32'd256);

`ifdef ICACHE_LOADER_CHECKSUM_EN
        // Checksum good / bad / good-reload
        dbuf[0] = 16'h1234; dbuf[1] = 16'h00FF;
        load(8'h30, 16'h0002, 0, 1'b0);
        chk("chk_good_err", {31'h0, err}, 32'h0);
        finish_load(1'b1);
        load(8'h30, 16'h0002, 0, 1'b1);
        chk("chk_bad_err", {31'h0, err}, 32'h1);
        finish_load(1'b0);
        idle(3);
        chk("chk_bad_sticky", {31'h0, err}, 32'h1);
        chk("chk_bad_nrst_low", {31'h0, tile_nrst}, 32'h0);
        load(8'h30, 16'h0002, 0, 1'b0);
        chk("chk_reload_err", {31'h0, err}, 32'h0);
        finish_load(1'b1);
`endif

        // Reset mid-load after 2 of 5 data beats
        for (int i = 0; i < 5; i++) dbuf[i] = 16'hC000 + 16'(i);
        send(16'h0040);
        send(16'h0005);
        for (int i = 0; i < 2; i++) begin : partial
            wr_t e;
            e.a = 8'h40 + 8'(i);
            e.d = dbuf[i];
            sb_q.push_back(e);
            send(dbuf[i]);
        end
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset();
        chk("rst_sb_drained", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        load(8'h40, 16'h0005, 0, 1'b0);
        finish_load(1'b1);

        // Back-to-back: next address word offered during DONE
        dbuf[0] = 16'hBEEF;
        load(8'h80, 16'h0001, 0, 1'b0);
        s_data = 16'h0090;
        #1;
        chk("b2b_ready_low", {31'h0, s_ready}, 32'h0);
        chk("b2b_done", {31'h0, load_done}, 32'h1);
        @(posedge clk);
        #1;
        chk("b2b_nrst_high", {31'h0, tile_nrst}, 32'h1);
        chk("b2b_ready_idle", {31'h0, s_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("b2b_nrst_drop", {31'h0, tile_nrst}, 32'h0);
        chk("b2b_busy", {31'h0, busy}, 32'h1);
        send(16'h0000);
`ifdef ICACHE_LOADER_CHECKSUM_EN
        send(16'h0000);
`endif
        finish_load(1'b1);

        idle(4);
        chk("sb_empty_end", sb_q.size(), 32'd0);
        chk("err_end", {31'h0, err}, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
